int_iq_select: RTL and testbench

Wakeup/select scheduler for the integer issue queue. It tracks readiness and age for each ENTRIES slot and allocates up to two slots per cycle from RNDS. Each cycle it grants the two oldest ready slots to the ALU0/ALU1 issue ports. It broadcasts the granted destination tags for back-to-back wakeup. Payload storage is external and indexed by the slot numbers this block produces; the block drives the instr0/instr1 valid and wakeup fields of the INT issue-queue interface.

---
 rtl/int_iq_select.sv | 247 ++++++++++++++++++++++++
 tb/tb_int_iq_select.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_iq_select.sv
// int_iq_select: wakeup/select scheduler for the integer issue queue.
// Tracks per-slot source readiness plus a pairwise age matrix, allocates up to
// two slots per cycle and grants the two oldest ready slots to ALU0/ALU1.
// Payload storage lives outside this block and is indexed by the slot numbers
// produced here.
// Optional feature macro: FALCO_IQ_B2B_WAKEUP_EN drives the back-to-back
// destination-tag broadcast and feeds it back as an internal wakeup source.
module int_iq_select #(
    parameter int ENTRIES = 8,
    parameter int PRF_W   = 6,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 stall_i,
    input  logic                 alloc0_valid_i,
    input  logic                 alloc1_valid_i,
    input  logic [PRF_W-1:0]     alloc0_rs1_i,
    input  logic [PRF_W-1:0]     alloc0_rs2_i,
    input  logic [PRF_W-1:0]     alloc0_rd_i,
    input  logic [PRF_W-1:0]     alloc1_rs1_i,
    input  logic [PRF_W-1:0]     alloc1_rs2_i,
    input  logic [PRF_W-1:0]     alloc1_rd_i,
    input  logic                 alloc0_rs1_rdy_i,
    input  logic                 alloc0_rs2_rdy_i,
    input  logic                 alloc0_rd_valid_i,
    input  logic                 alloc1_rs1_rdy_i,
    input  logic                 alloc1_rs2_rdy_i,
    input  logic                 alloc1_rd_valid_i,
    output logic                 alloc_ready_o,
    output logic [IDX_W-1:0]     alloc0_idx_o,
    output logic [IDX_W-1:0]     alloc1_idx_o,
    input  logic [1:0]           wb_wakeup_valid_i,
    input  logic [2*PRF_W-1:0]   wb_wakeup_rd_i,
    output logic                 instr0_valid_o,
    output logic                 instr1_valid_o,
    output logic [IDX_W-1:0]     issue0_idx_o,
    output logic [IDX_W-1:0]     issue1_idx_o,
    output logic                 issue_alu0_rd_valid_o,
    output logic                 issue_alu1_rd_valid_o,
    output logic [PRF_W-1:0]     issue_alu0_rd_o,
    output logic [PRF_W-1:0]     issue_alu1_rd_o
);
    localparam int NWAKE = 4;
    localparam int CNT_W = IDX_W + 1;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [ENTRIES-1:0] rs1Rdy_q, rs1Rdy_d;
    logic [ENTRIES-1:0] rs2Rdy_q, rs2Rdy_d;
    logic [ENTRIES-1:0] rdValid_q, rdValid_d;
    logic [PRF_W-1:0]   rs1_q [ENTRIES];
    logic [PRF_W-1:0]   rs1_d [ENTRIES];
    logic [PRF_W-1:0]   rs2_q [ENTRIES];
    logic [PRF_W-1:0]   rs2_d [ENTRIES];
    logic [PRF_W-1:0]   rd_q  [ENTRIES];
    logic [PRF_W-1:0]   rd_d  [ENTRIES];
    // older_q[i][j] = 1 means slot j is older than slot i
    logic [ENTRIES-1:0] older_q [ENTRIES];
    logic [ENTRIES-1:0] older_d [ENTRIES];

    logic [CNT_W-1:0]   freeCount;
    logic [IDX_W-1:0]   free0Idx, free1Idx;
    logic               found0, found1;
    logic [ENTRIES-1:0] readyVec, grant0Vec, grant1Vec;
    logic [IDX_W-1:0]   grant0Idx, grant1Idx;
    logic [NWAKE-1:0]   wakeValid;
    logic [NWAKE-1:0][PRF_W-1:0] wakeTag;
    logic               doAlloc0, doAlloc1;
    logic [IDX_W-1:0]   slot0, slot1;

    function automatic logic tagHit(input logic [PRF_W-1:0] tag,
                                    input logic [NWAKE-1:0] vld,
                                    input logic [NWAKE-1:0][PRF_W-1:0] tags);
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < NWAKE; w++) begin
            if (vld[w] && (tags[w] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    // Count free slots and find the two lowest free indices
    always_comb begin
        freeCount = '0;
        free0Idx  = '0;
        free1Idx  = '0;
        found0    = 1'b0;
        found1    = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!valid_q[i]) begin
                freeCount = freeCount + CNT_W'(1);
                if (!found0) begin
                    found0   = 1'b1;
                    free0Idx = IDX_W'(i);
                end else if (!found1) begin
                    found1   = 1'b1;
                    free1Idx = IDX_W'(i);
                end
            end
        end
    end

    // Allocation handshake; alloc1 slides down to the lowest slot when it is alone
    always_comb begin
        alloc_ready_o = (freeCount >= CNT_W'(2));
        alloc0_idx_o  = free0Idx;
        alloc1_idx_o  = (alloc1_valid_i && !alloc0_valid_i) ? free0Idx : free1Idx;
    end

    // Age-ordered select: grant0 has no ready older slot, grant1 is oldest of the rest
    always_comb begin
        grant0Vec = '0;
        grant1Vec = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            readyVec[i] = valid_q[i] & rs1Rdy_q[i] & rs2Rdy_q[i];
        end
        for (int i = 0; i < ENTRIES; i++) begin
            if (readyVec[i] && ((older_q[i] & readyVec) == '0)) grant0Vec[i] = 1'b1;
        end
        for (int i = 0; i < ENTRIES; i++) begin
            if (readyVec[i] && !grant0Vec[i] &&
                ((older_q[i] & readyVec & ~grant0Vec) == '0)) grant1Vec[i] = 1'b1;
        end
        if (stall_i || flush_i) begin
            grant0Vec = '0;
            grant1Vec = '0;
        end
    end

    // Encode the one-hot grants into slot indices
    always_comb begin
        grant0Idx = '0;
        grant1Idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (grant0Vec[i]) grant0Idx = IDX_W'(i);
            if (grant1Vec[i]) grant1Idx = IDX_W'(i);
        end
    end

    // Issue port outputs, all zero when the port has no grant
    always_comb begin
        instr0_valid_o  = |grant0Vec;
        instr1_valid_o  = |grant1Vec;
        issue0_idx_o    = grant0Idx;
        issue1_idx_o    = grant1Idx;
        issue_alu0_rd_o = instr0_valid_o ? rd_q[grant0Idx] : '0;
        issue_alu1_rd_o = instr1_valid_o ? rd_q[grant1Idx] : '0;
`ifdef FALCO_IQ_B2B_WAKEUP_EN
        issue_alu0_rd_valid_o = instr0_valid_o & rdValid_q[grant0Idx];
        issue_alu1_rd_valid_o = instr1_valid_o & rdValid_q[grant1Idx];
`else
        issue_alu0_rd_valid_o = 1'b0;
        issue_alu1_rd_valid_o = 1'b0;
`endif
    end

`ifndef FALCO_IQ_B2B_WAKEUP_EN
    // Without the broadcast the stored rd_valid flags have no consumer
    logic unusedRdValid;
    assign unusedRdValid = ^rdValid_q;
`endif

    // Gather this cycle's wakeup tags: writeback ports plus optional grant broadcasts
    always_comb begin
        wakeValid  = '0;
        wakeTag    = '0;
        wakeValid[0] = wb_wakeup_valid_i[0];
        wakeTag[0]   = wb_wakeup_rd_i[PRF_W-1:0];
        wakeValid[1] = wb_wakeup_valid_i[1];
        wakeTag[1]   = wb_wakeup_rd_i[2*PRF_W-1:PRF_W];
`ifdef FALCO_IQ_B2B_WAKEUP_EN
        wakeValid[2] = issue_alu0_rd_valid_o;
        wakeTag[2]   = issue_alu0_rd_o;
        wakeValid[3] = issue_alu1_rd_valid_o;
        wakeTag[3]   = issue_alu1_rd_o;
`endif
    end

    // Next state: retire grants, apply wakeups, write allocations (with bypass), flush
    always_comb begin
        rs1Rdy_d  = rs1Rdy_q;
        rs2Rdy_d  = rs2Rdy_q;
        rdValid_d = rdValid_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        older_d   = older_q;
        doAlloc0  = alloc0_valid_i & alloc_ready_o & ~flush_i;
        doAlloc1  = alloc1_valid_i & alloc_ready_o & ~flush_i;
        slot0     = free0Idx;
        slot1     = doAlloc0 ? free1Idx : free0Idx;
        valid_d   = valid_q & ~(grant0Vec | grant1Vec);
        for (int i = 0; i < ENTRIES; i++) begin
            if (tagHit(rs1_q[i], wakeValid, wakeTag)) rs1Rdy_d[i] = 1'b1;
            if (tagHit(rs2_q[i], wakeValid, wakeTag)) rs2Rdy_d[i] = 1'b1;
        end
        if (doAlloc0) begin
            valid_d[slot0]   = 1'b1;
            rs1_d[slot0]     = alloc0_rs1_i;
            rs2_d[slot0]     = alloc0_rs2_i;
            rd_d[slot0]      = alloc0_rd_i;
            rdValid_d[slot0] = alloc0_rd_valid_i;
            rs1Rdy_d[slot0]  = alloc0_rs1_rdy_i | tagHit(alloc0_rs1_i, wakeValid, wakeTag);
            rs2Rdy_d[slot0]  = alloc0_rs2_rdy_i | tagHit(alloc0_rs2_i, wakeValid, wakeTag);
            older_d[slot0]   = valid_q;
            for (int j = 0; j < ENTRIES; j++) older_d[j][slot0] = 1'b0;
        end
        if (doAlloc1) begin
            valid_d[slot1]   = 1'b1;
            rs1_d[slot1]     = alloc1_rs1_i;
            rs2_d[slot1]     = alloc1_rs2_i;
            rd_d[slot1]      = alloc1_rd_i;
            rdValid_d[slot1] = alloc1_rd_valid_i;
            rs1Rdy_d[slot1]  = alloc1_rs1_rdy_i | tagHit(alloc1_rs1_i, wakeValid, wakeTag);
            rs2Rdy_d[slot1]  = alloc1_rs2_rdy_i | tagHit(alloc1_rs2_i, wakeValid, wakeTag);
            older_d[slot1]   = valid_q;
            if (doAlloc0) older_d[slot1][slot0] = 1'b1;
            for (int j = 0; j < ENTRIES; j++) older_d[j][slot1] = 1'b0;
        end
        if (flush_i) valid_d = '0;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q   <= '0;
            rs1Rdy_q  <= '0;
            rs2Rdy_q  <= '0;
            rdValid_q <= '0;
            rs1_q     <= '{default: '0};
            rs2_q     <= '{default: '0};
            rd_q      <= '{default: '0};
            older_q   <= '{default: '0};
        end else begin
            valid_q   <= valid_d;
            rs1Rdy_q  <= rs1Rdy_d;
            rs2Rdy_q  <= rs2Rdy_d;
            rdValid_q <= rdValid_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            older_q   <= older_d;
        end
    end

endmodule

// File: tb/tb_int_iq_select.sv
// tb_int_iq_select: scoreboard bench for int_iq_select.
// The driver predicts each cycle's outputs from a slot/sequence-number model
// and queues them; a monitor pops and compares at the falling edge.
module tb_int_iq_select;
    localparam int ENTRIES = 8;
    localparam int PRF_W   = 6;
    localparam int IDX_W   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, flush, stall, a0v, a1v;
    logic [PRF_W-1:0] a0rs1, a0rs2, a0rd, a1rs1, a1rs2, a1rd;
    logic a0r1, a0r2, a0rdv, a1r1, a1r2, a1rdv;
    logic [1:0] wbV;
    logic [2*PRF_W-1:0] wbRd;
    logic allocReady, i0v, i1v, r0v, r1v;
    logic [IDX_W-1:0] a0Idx, a1Idx, i0Idx, i1Idx;
    logic [PRF_W-1:0] r0, r1;

    int_iq_select #(.ENTRIES(ENTRIES), .PRF_W(PRF_W)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .stall_i(stall),
        .alloc0_valid_i(a0v), .alloc1_valid_i(a1v),
        .alloc0_rs1_i(a0rs1), .alloc0_rs2_i(a0rs2), .alloc0_rd_i(a0rd),
        .alloc1_rs1_i(a1rs1), .alloc1_rs2_i(a1rs2), .alloc1_rd_i(a1rd),
        .alloc0_rs1_rdy_i(a0r1), .alloc0_rs2_rdy_i(a0r2), .alloc0_rd_valid_i(a0rdv),
        .alloc1_rs1_rdy_i(a1r1), .alloc1_rs2_rdy_i(a1r2), .alloc1_rd_valid_i(a1rdv),
        .alloc_ready_o(allocReady), .alloc0_idx_o(a0Idx), .alloc1_idx_o(a1Idx),
        .wb_wakeup_valid_i(wbV), .wb_wakeup_rd_i(wbRd),
        .instr0_valid_o(i0v), .instr1_valid_o(i1v),
        .issue0_idx_o(i0Idx), .issue1_idx_o(i1Idx),
        .issue_alu0_rd_valid_o(r0v), .issue_alu1_rd_valid_o(r1v),
        .issue_alu0_rd_o(r0), .issue_alu1_rd_o(r1)
    );

    typedef struct packed {
        logic             allocReady;
        logic [IDX_W-1:0] a0Idx;
        logic [IDX_W-1:0] a1Idx;
        logic             i0v;
        logic [IDX_W-1:0] i0Idx;
        logic             r0v;
        logic [PRF_W-1:0] r0;
        logic             i1v;
        logic [IDX_W-1:0] i1Idx;
        logic             r1v;
        logic [PRF_W-1:0] r1;
    } outT;

    typedef struct packed {
        logic care;
        outT  o;
    } expT;

    expT expQ[$];
    int nCompared = 0;
    int nMismatched = 0;
    int monCycle = 0;

    // Reference model: a slot array where age is a monotonically increasing sequence number
    logic             mValid [ENTRIES];
    logic [PRF_W-1:0] mRs1   [ENTRIES];
    logic [PRF_W-1:0] mRs2   [ENTRIES];
    logic [PRF_W-1:0] mRd    [ENTRIES];
    logic             mR1    [ENTRIES];
    logic             mR2    [ENTRIES];
    logic             mRdV   [ENTRIES];
    int               mSeq   [ENTRIES];
    int               seqNext;
    logic             wkV    [4];
    logic [PRF_W-1:0] wkT    [4];

    function automatic logic slotReady(input int i);
        return mValid[i] && mR1[i] && mR2[i];
    endfunction

    function automatic logic hitTag(input logic [PRF_W-1:0] t);
        logic h;
        h = 1'b0;
        for (int w = 0; w < 4; w++) if (wkV[w] && wkT[w] == t) h = 1'b1;
        return h;
    endfunction

    task automatic modelSelect(output int g0, output int g1);
        g0 = -1;
        g1 = -1;
        if (!stall && !flush) begin
            for (int i = 0; i < ENTRIES; i++)
                if (slotReady(i) && (g0 < 0 || mSeq[i] < mSeq[g0])) g0 = i;
            for (int i = 0; i < ENTRIES; i++)
                if (i != g0 && slotReady(i) && (g1 < 0 || mSeq[i] < mSeq[g1])) g1 = i;
        end
    endtask

    task automatic commitModel(input int g0, input int g1);
        int fl[$];
        logic doA0, doA1;
        int s0, s1;
        if (rst || flush) begin
            for (int i = 0; i < ENTRIES; i++) mValid[i] = 1'b0;
            return;
        end
        for (int i = 0; i < ENTRIES; i++) if (!mValid[i]) fl.push_back(i);
        for (int w = 0; w < 4; w++) begin
            wkV[w] = 1'b0;
            wkT[w] = '0;
        end
        wkV[0] = wbV[0]; wkT[0] = wbRd[PRF_W-1:0];
        wkV[1] = wbV[1]; wkT[1] = wbRd[2*PRF_W-1:PRF_W];
`ifdef FALCO_IQ_B2B_WAKEUP_EN
        if (g0 >= 0) begin wkV[2] = mRdV[g0]; wkT[2] = mRd[g0]; end
        if (g1 >= 0) begin wkV[3] = mRdV[g1]; wkT[3] = mRd[g1]; end
`endif
        if (g0 >= 0) mValid[g0] = 1'b0;
        if (g1 >= 0) mValid[g1] = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (hitTag(mRs1[i])) mR1[i] = 1'b1;
            if (hitTag(mRs2[i])) mR2[i] = 1'b1;
        end
        doA0 = a0v && (fl.size() >= 2);
        doA1 = a1v && (fl.size() >= 2);
        if (doA0) begin
            s0 = fl[0];
            mValid[s0] = 1'b1; mRs1[s0] = a0rs1; mRs2[s0] = a0rs2; mRd[s0] = a0rd;
            mRdV[s0] = a0rdv; mR1[s0] = a0r1 | hitTag(a0rs1); mR2[s0] = a0r2 | hitTag(a0rs2);
            mSeq[s0] = seqNext; seqNext++;
        end
        if (doA1) begin
            s1 = doA0 ? fl[1] : fl[0];
            mValid[s1] = 1'b1; mRs1[s1] = a1rs1; mRs2[s1] = a1rs2; mRd[s1] = a1rd;
            mRdV[s1] = a1rdv; mR1[s1] = a1r1 | hitTag(a1rs1); mR2[s1] = a1r2 | hitTag(a1rs2);
            mSeq[s1] = seqNext; seqNext++;
        end
    endtask

    // Predict this cycle's outputs, queue them, then advance the model across the edge
    task automatic applyStimulus();
        expT e;
        int g0, g1;
        int fl[$];
        for (int i = 0; i < ENTRIES; i++) if (!mValid[i]) fl.push_back(i);
        modelSelect(g0, g1);
        e = '0;
        e.o.allocReady = (fl.size() >= 2);
        e.care = e.o.allocReady;
        if (e.care) begin
            e.o.a0Idx = IDX_W'(fl[0]);
            e.o.a1Idx = (a1v && !a0v) ? IDX_W'(fl[0]) : IDX_W'(fl[1]);
        end
        if (g0 >= 0) begin
            e.o.i0v = 1'b1; e.o.i0Idx = IDX_W'(g0); e.o.r0 = mRd[g0];
`ifdef FALCO_IQ_B2B_WAKEUP_EN
            e.o.r0v = mRdV[g0];
`endif
        end
        if (g1 >= 0) begin
            e.o.i1v = 1'b1; e.o.i1Idx = IDX_W'(g1); e.o.r1 = mRd[g1];
`ifdef FALCO_IQ_B2B_WAKEUP_EN
            e.o.r1v = mRdV[g1];
`endif
        end
        expQ.push_back(e);
        @(posedge clk);
        #1;
        commitModel(g0, g1);
    endtask

    task automatic checkOutput(input expT e);
        outT act;
        act.allocReady = allocReady;
        act.a0Idx = e.care ? a0Idx : '0;
        act.a1Idx = e.care ? a1Idx : '0;
        act.i0v = i0v; act.i0Idx = i0Idx; act.r0v = r0v; act.r0 = r0;
        act.i1v = i1v; act.i1Idx = i1Idx; act.r1v = r1v; act.r1 = r1;
        nCompared++;
        if (act !== e.o) begin
            nMismatched++;
            $display("[TB] FAIL outputs cycle %0d: actual rdy=%b a0=%0d a1=%0d i0=%b/%0d/%b/%0d i1=%b/%0d/%b/%0d required rdy=%b a0=%0d a1=%0d i0=%b/%0d/%b/%0d i1=%b/%0d/%b/%0d",
                     monCycle, act.allocReady, act.a0Idx, act.a1Idx, act.i0v, act.i0Idx, act.r0v, act.r0,
                     act.i1v, act.i1Idx, act.r1v, act.r1, e.o.allocReady, e.o.a0Idx, e.o.a1Idx,
                     e.o.i0v, e.o.i0Idx, e.o.r0v, e.o.r0, e.o.i1v, e.o.i1Idx, e.o.r1v, e.o.r1);
        end
    endtask

    // Monitor: compare the oldest prediction against the DUT mid-cycle
    initial begin
        expT e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
            monCycle++;
        end
    end

    task automatic clearInputs();
        rst = 1'b0; flush = 1'b0; stall = 1'b0; a0v = 1'b0; a1v = 1'b0;
        a0rs1 = '0; a0rs2 = '0; a0rd = '0; a1rs1 = '0; a1rs2 = '0; a1rd = '0;
        a0r1 = 1'b0; a0r2 = 1'b0; a0rdv = 1'b0; a1r1 = 1'b0; a1r2 = 1'b0; a1rdv = 1'b0;
        wbV = '0; wbRd = '0;
    endtask

    task automatic setAlloc0(input logic v, input int s1, input int s2, input int d,
                             input logic rd1, input logic rd2, input logic dv);
        a0v = v; a0rs1 = PRF_W'(s1); a0rs2 = PRF_W'(s2); a0rd = PRF_W'(d);
        a0r1 = rd1; a0r2 = rd2; a0rdv = dv;
    endtask

    task automatic setAlloc1(input logic v, input int s1, input int s2, input int d,
                             input logic rd1, input logic rd2, input logic dv);
        a1v = v; a1rs1 = PRF_W'(s1); a1rs2 = PRF_W'(s2); a1rd = PRF_W'(d);
        a1r1 = rd1; a1r2 = rd2; a1rdv = dv;
    endtask

    initial begin
        clearInputs();
        rst = 1'b1;
        seqNext = 0;
        for (int i = 0; i < ENTRIES; i++) begin
            mValid[i] = 1'b0; mR1[i] = 1'b0; mR2[i] = 1'b0; mRdV[i] = 1'b0;
            mRs1[i] = '0; mRs2[i] = '0; mRd[i] = '0; mSeq[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle after reset
        applyStimulus();
        applyStimulus();

        // Producer A (rd=5) and dependent B (rs1=5) allocated together
        setAlloc0(1, 1, 2, 5, 1, 1, 1);
        setAlloc1(1, 5, 3, 6, 0, 1, 1);
        applyStimulus();
        clearInputs();
        repeat (3) applyStimulus();
        wbV = 2'b01; wbRd = {6'd0, 6'd5};
        applyStimulus();
        clearInputs();
        repeat (3) applyStimulus();

        // Fill all eight slots while stalled, then drain in pairs
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            setAlloc0(1, 10 + k, 11 + k, 30 + 2 * k, 1, 1, 1);
            setAlloc1(1, 12 + k, 13 + k, 31 + 2 * k, 1, 1, 1);
            applyStimulus();
        end
        stall = 1'b0;
        applyStimulus();
        clearInputs();
        repeat (5) applyStimulus();

        // Age beats index: reused slot 0 is younger than slot 3
        stall = 1'b1;
        setAlloc0(1, 1, 1, 7, 1, 1, 1);
        setAlloc1(1, 20, 1, 8, 0, 1, 1);
        applyStimulus();
        setAlloc0(1, 20, 2, 9, 0, 1, 1);
        setAlloc1(1, 21, 2, 10, 0, 1, 1);
        applyStimulus();
        clearInputs();
        applyStimulus();
        setAlloc0(1, 3, 3, 11, 1, 1, 1);
        wbV = 2'b10; wbRd = {6'd21, 6'd0};
        applyStimulus();
        clearInputs();
        applyStimulus();
        wbV = 2'b01; wbRd = {6'd0, 6'd20};
        applyStimulus();
        clearInputs();
        repeat (3) applyStimulus();

        // Stall holds two ready slots, release grants both
        stall = 1'b1;
        setAlloc0(1, 4, 4, 12, 1, 1, 0);
        setAlloc1(1, 4, 4, 13, 1, 1, 1);
        applyStimulus();
        clearInputs();
        stall = 1'b1;
        repeat (2) applyStimulus();
        stall = 1'b0;
        repeat (2) applyStimulus();

        // Flush a full queue with an allocation pending
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            setAlloc0(1, 1, 1, 40 + k, 1, 1, 1);
            setAlloc1(1, 1, 1, 50 + k, 1, 1, 1);
            applyStimulus();
        end
        clearInputs();
        flush = 1'b1;
        setAlloc0(1, 1, 1, 60, 1, 1, 1);
        setAlloc1(1, 1, 1, 61, 1, 1, 1);
        applyStimulus();
        clearInputs();
        repeat (2) applyStimulus();

        // Randomized traffic including occasional flush and reset
        for (int c = 0; c < 500; c++) begin
            rst   = ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 39) == 0);
            stall = ($urandom_range(0, 5) == 0);
            setAlloc0($urandom_range(0, 9) < 6, $urandom_range(0, 15), $urandom_range(0, 15),
                      $urandom_range(0, 15), $urandom_range(0, 1) == 1,
                      $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
            setAlloc1($urandom_range(0, 9) < 6, $urandom_range(0, 15), $urandom_range(0, 15),
                      $urandom_range(0, 15), $urandom_range(0, 1) == 1,
                      $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
            wbV[0] = ($urandom_range(0, 9) < 4);
            wbV[1] = ($urandom_range(0, 9) < 4);
            wbRd = {PRF_W'($urandom_range(0, 15)), PRF_W'($urandom_range(0, 15))};
            applyStimulus();
        end
        clearInputs();
        repeat (2) applyStimulus();

        repeat (3) @(negedge clk);
        if (expQ.size() != 0) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL drain: %0d predictions left unchecked, required 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
